// File: rtl/drive_via6522_if.sv
// CPU-side bus of the drive VIA: phase strobes, register select, read/write
// qualifiers and the two data paths.
//   rising / falling : one-cycle phase-2 start / end strobes
//   addr             : register select
//   wen / ren        : write / read access this bus cycle
//   data_in          : CPU write data
//   data_out         : read data, combinational from addr
interface drive_via6522_if;
    logic       rising;
    logic       falling;
    logic [3:0] addr;
    logic       wen;
    logic       ren;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output rising, falling, addr, wen, ren, data_in, input data_out);
    modport slave  (input rising, falling, addr, wen, ren, data_in, output data_out);
endinterface

// File: rtl/drive_via6522.sv
// Cycle-based MOS 6522 VIA as used in the 1541 drive. All state changes on the
// falling (end of phase 2) strobe.
//   clock, reset        : system clock, synchronous active-high reset
//   bus                 : CPU register access (drive_via6522_if.slave)
//   port_a_* / port_b_* : output register, drive enable (DDR), pin level
//   ca1_i, cb1_i        : edge-sensitive control inputs
//   ca2_* / cb2_*       : CA2/CB2 level, drive enable, input
//   cb1_o / cb1_t       : tied high / undriven
//   irq                 : active-high interrupt request
module drive_via6522 (
    input  logic              clock,
    input  logic              reset,
    drive_via6522_if.slave    bus,
    output logic [7:0]        port_a_o,
    output logic [7:0]        port_a_t,
    input  logic [7:0]        port_a_i,
    output logic [7:0]        port_b_o,
    output logic [7:0]        port_b_t,
    input  logic [7:0]        port_b_i,
    input  logic              ca1_i,
    output logic              ca2_o,
    output logic              ca2_t,
    input  logic              ca2_i,
    output logic              cb1_o,
    output logic              cb1_t,
    input  logic              cb1_i,
    output logic              cb2_o,
    output logic              cb2_t,
    input  logic              cb2_i,
    output logic              irq
);

    typedef enum logic [2:0] {
        C2_IN_NEG, C2_IN_NEG_IND, C2_IN_POS, C2_IN_POS_IND,
        C2_HANDSHAKE, C2_PULSE, C2_LOW, C2_HIGH
    } ctl2_e;

    logic [7:0]  ora, orb, ddra, ddrb, acr, pcr, sr;
    logic [7:0]  pa_latch, pb_latch, t2_latch_lo, pb_read;
    logic [6:0]  ifr, ier, ifr_set, ifr_clr;
    logic [15:0] t1_cnt, t1_latch, t2_cnt;
    logic        t1_armed, t1_reload, t2_armed, pb7_out, ca2_out, cb2_out;
    logic        ca1_prev, ca2_prev, cb1_prev, cb2_prev, pb6_prev;
    logic        wr, acc;
    logic [15:0] sel, wr_sel, rd_sel, acc_sel;
    logic        ca1_edge, ca2_edge, cb1_edge, cb2_edge;
    logic        t1_load, t1_dec, t1_uflow, t2_load, t2_dec, t2_uflow;
    ctl2_e       ca2_mode, cb2_mode;
    logic        unused_ok;

    assign unused_ok = &{1'b0, bus.rising};

    assign wr      = bus.falling & bus.wen;
    assign acc     = bus.falling & (bus.wen | bus.ren);
    assign sel     = 16'd1 << bus.addr;
    assign wr_sel  = wr ? sel : '0;
    assign rd_sel  = (bus.falling & bus.ren) ? sel : '0;
    assign acc_sel = acc ? sel : '0;

    assign ca2_mode = ctl2_e'(pcr[3:1]);
    assign cb2_mode = ctl2_e'(pcr[7:5]);

    assign pb_read = (orb & ddrb) | (port_b_i & ~ddrb);

    assign ca1_edge = bus.falling & (pcr[0] ? (~ca1_prev & ca1_i) : (ca1_prev & ~ca1_i));
    assign cb1_edge = bus.falling & (pcr[4] ? (~cb1_prev & cb1_i) : (cb1_prev & ~cb1_i));
    assign ca2_edge = bus.falling & ~pcr[3] & (pcr[2] ? (~ca2_prev & ca2_i) : (ca2_prev & ~ca2_i));
    assign cb2_edge = bus.falling & ~pcr[7] & (pcr[6] ? (~cb2_prev & cb2_i) : (cb2_prev & ~cb2_i));

    // T1 neither decrements on its load strobe nor on the free-run reload strobe
    assign t1_load  = wr_sel[5];
    assign t1_dec   = bus.falling & ~t1_load & ~t1_reload;
    assign t1_uflow = t1_dec & (t1_cnt == 16'h0000);

    assign t2_load  = wr_sel[9];
    assign t2_dec   = bus.falling & ~t2_load & (~acr[5] | (pb6_prev & ~port_b_i[6]));
    assign t2_uflow = t2_dec & (t2_cnt == 16'h0000);

    always_comb begin
        ifr_set    = '0;
        ifr_set[0] = ca2_edge;
        ifr_set[1] = ca1_edge;
        ifr_set[3] = cb2_edge;
        ifr_set[4] = cb1_edge;
        ifr_set[5] = t2_uflow & t2_armed;
        ifr_set[6] = t1_uflow & t1_armed;

        ifr_clr = '0;
        if (wr_sel[13])
            ifr_clr = bus.data_in[6:0];
        if (acc_sel[1]) begin
            ifr_clr[1] = 1'b1;
            if (ca2_mode != C2_IN_NEG_IND && ca2_mode != C2_IN_POS_IND)
                ifr_clr[0] = 1'b1;
        end
        if (acc_sel[0]) begin
            ifr_clr[4] = 1'b1;
            if (cb2_mode != C2_IN_NEG_IND && cb2_mode != C2_IN_POS_IND)
                ifr_clr[3] = 1'b1;
        end
        if (acc_sel[10])
            ifr_clr[2] = 1'b1;
        if (rd_sel[4] | wr_sel[5] | wr_sel[7])
            ifr_clr[6] = 1'b1;
        if (rd_sel[8] | wr_sel[9])
            ifr_clr[5] = 1'b1;
    end

    always_comb begin
        bus.data_out = '0;
        case (bus.addr)
            4'h0:        bus.data_out = acr[1] ? pb_latch : pb_read;
            4'h1, 4'hF:  bus.data_out = acr[0] ? pa_latch : port_a_i;
            4'h2:        bus.data_out = ddrb;
            4'h3:        bus.data_out = ddra;
            4'h4:        bus.data_out = t1_cnt[7:0];
            4'h5:        bus.data_out = t1_cnt[15:8];
            4'h6:        bus.data_out = t1_latch[7:0];
            4'h7:        bus.data_out = t1_latch[15:8];
            4'h8:        bus.data_out = t2_cnt[7:0];
            4'h9:        bus.data_out = t2_cnt[15:8];
            4'hA:        bus.data_out = sr;
            4'hB:        bus.data_out = acr;
            4'hC:        bus.data_out = pcr;
            4'hD:        bus.data_out = {irq, ifr};
            default:     bus.data_out = {1'b1, ier};
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ora <= '0; orb <= '0; ddra <= '0; ddrb <= '0;
            acr <= '0; pcr <= '0; sr <= '0;
            ifr <= '0; ier <= '0;
            pa_latch <= '0; pb_latch <= '0;
            t1_cnt <= '0; t1_latch <= '0; t2_cnt <= '0; t2_latch_lo <= '0;
            t1_armed <= 1'b0; t1_reload <= 1'b0; t2_armed <= 1'b0;
            pb7_out <= 1'b0; ca2_out <= 1'b0; cb2_out <= 1'b0;
            ca1_prev <= 1'b0; ca2_prev <= 1'b0; cb1_prev <= 1'b0;
            cb2_prev <= 1'b0; pb6_prev <= 1'b0;
        end else begin
            // set/clear vectors are already qualified by the falling strobe
            ifr <= (ifr & ~ifr_clr) | ifr_set;
            if (bus.falling) begin
                ca1_prev <= ca1_i;
                ca2_prev <= ca2_i;
                cb1_prev <= cb1_i;
                cb2_prev <= cb2_i;
                pb6_prev <= port_b_i[6];
                if (ca1_edge) pa_latch <= port_a_i;
                if (cb1_edge) pb_latch <= pb_read;

                if (wr) begin
                    case (bus.addr)
                        4'h0:       orb <= bus.data_in;
                        4'h1, 4'hF: ora <= bus.data_in;
                        4'h2:       ddrb <= bus.data_in;
                        4'h3:       ddra <= bus.data_in;
                        4'h4, 4'h6: t1_latch[7:0] <= bus.data_in;
                        4'h5, 4'h7: t1_latch[15:8] <= bus.data_in;
                        4'h8:       t2_latch_lo <= bus.data_in;
                        4'hA:       sr <= bus.data_in;
                        4'hB:       acr <= bus.data_in;
                        4'hC:       pcr <= bus.data_in;
                        4'hE:       ier <= bus.data_in[7] ? (ier | bus.data_in[6:0])
                                                          : (ier & ~bus.data_in[6:0]);
                        default:    ;
                    endcase
                end

                // Free-run: the strobe after underflow reloads instead of decrementing
                if (t1_load) begin
                    t1_cnt    <= {bus.data_in, t1_latch[7:0]};
                    t1_armed  <= 1'b1;
                    t1_reload <= 1'b0;
                    pb7_out   <= 1'b0;
                end else if (t1_reload) begin
                    t1_cnt    <= t1_latch;
                    t1_reload <= 1'b0;
                end else begin
                    t1_cnt <= t1_cnt - 16'd1;
                    if (t1_uflow) begin
                        t1_reload <= acr[6];
                        if (t1_armed) begin
                            pb7_out <= ~pb7_out;
                            if (!acr[6]) t1_armed <= 1'b0;
                        end
                    end
                end

                if (t2_load) begin
                    t2_cnt   <= {bus.data_in, t2_latch_lo};
                    t2_armed <= 1'b1;
                end else if (t2_dec) begin
                    t2_cnt <= t2_cnt - 16'd1;
                    if (t2_uflow) t2_armed <= 1'b0;
                end

                case (ca2_mode)
                    C2_HANDSHAKE: begin
                        if (acc_sel[1])    ca2_out <= 1'b0;
                        else if (ca1_edge) ca2_out <= 1'b1;
                    end
                    C2_PULSE: ca2_out <= ~acc_sel[1];
                    C2_LOW:   ca2_out <= 1'b0;
                    C2_HIGH:  ca2_out <= 1'b1;
                    default:  ;
                endcase

                case (cb2_mode)
                    C2_HANDSHAKE: begin
                        if (wr_sel[0])     cb2_out <= 1'b0;
                        else if (cb1_edge) cb2_out <= 1'b1;
                    end
                    C2_PULSE: cb2_out <= ~wr_sel[0];
                    C2_LOW:   cb2_out <= 1'b0;
                    C2_HIGH:  cb2_out <= 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    assign port_a_o = ora;
    assign port_a_t = ddra;
    assign port_b_o = acr[7] ? {pb7_out, orb[6:0]} : orb;
    assign port_b_t = acr[7] ? {1'b1, ddrb[6:0]} : ddrb;
    assign ca2_o    = ca2_out;
    assign ca2_t    = pcr[3];
    assign cb1_o    = 1'b1;
    assign cb1_t    = 1'b0;
    assign cb2_o    = cb2_out;
    assign cb2_t    = pcr[7];
    assign irq      = |(ifr & ier);

endmodule

// File: tb/tb_drive_via6522.sv
// Self-checking bench for drive_via6522: expected values are queued when the
// stimulus is applied and popped when the DUT output is sampled.
module tb_drive_via6522;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] port_a_o, port_a_t, port_a_i;
    logic [7:0] port_b_o, port_b_t, port_b_i;
    logic       ca1_i, ca2_i, cb1_i, cb2_i;
    logic       ca2_o, ca2_t, cb1_o, cb1_t, cb2_o, cb2_t, irq;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got, want;

    always #5 clock = ~clock;

    drive_via6522_if bus ();

    drive_via6522 dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .port_a_o (port_a_o),
        .port_a_t (port_a_t),
        .port_a_i (port_a_i),
        .port_b_o (port_b_o),
        .port_b_t (port_b_t),
        .port_b_i (port_b_i),
        .ca1_i    (ca1_i),
        .ca2_o    (ca2_o),
        .ca2_t    (ca2_t),
        .ca2_i    (ca2_i),
        .cb1_o    (cb1_o),
        .cb1_t    (cb1_t),
        .cb1_i    (cb1_i),
        .cb2_o    (cb2_o),
        .cb2_t    (cb2_t),
        .cb2_i    (cb2_i),
        .irq      (irq)
    );

    // One bus cycle: rising strobe, then falling strobe; returns at a negedge
    task automatic strobe();
        @(negedge clock); bus.rising = 1'b1;
        @(negedge clock); bus.rising = 1'b0; bus.falling = 1'b1;
        @(negedge clock); bus.falling = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        bus.addr = a; bus.data_in = d; bus.wen = 1'b1;
        strobe();
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        bus.addr = a; bus.ren = 1'b1;
        #1 d = bus.data_out;
        strobe();
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        bus.addr = a;
        #1 d = bus.data_out;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) strobe();
        @(negedge clock); reset = 1'b0;
        for (int a = 0; a < 16; a++) exp_q.push_back(a == 14 ? 8'h80 : 8'h00);
        for (int a = 0; a < 16; a++) begin
            peek(4'(a), got);
            want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL reset_reg%0d: got %02h expected %02h", a, got, want); end
        end
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h02);
        got = port_a_t; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL reset_port_a_t: got %02h expected %02h", got, want); end
        got = port_b_t; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL reset_port_b_t: got %02h expected %02h", got, want); end
        got = {6'd0, cb1_o, irq}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL reset_cb1o_irq: got %02h expected %02h", got, want); end
    endtask

    task automatic test_ports();
        bus_write(4'h2, 8'h0F);
        bus_write(4'h0, 8'hA5);
        port_b_i = 8'h3C; port_a_i = 8'h5A;
        exp_q.push_back(8'h35);
        bus_read(4'h0, got); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL pb_read: got %02h expected %02h", got, want); end
        exp_q.push_back(8'hA5); exp_q.push_back(8'h0F); exp_q.push_back(8'h5A);
        got = port_b_o; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL port_b_o: got %02h expected %02h", got, want); end
        got = port_b_t; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL port_b_t: got %02h expected %02h", got, want); end
        peek(4'hF, got); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL pa_read: got %02h expected %02h", got, want); end
    endtask

    task automatic test_t1_oneshot();
        bus_write(4'h4, 8'h03);
        bus_write(4'hE, 8'hC0);
        bus_write(4'h5, 8'h00);
        repeat (3) strobe();
        exp_q.push_back(8'h00);
        got = {7'd0, irq}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t1_early_irq: got %02h expected %02h", got, want); end
        strobe();
        exp_q.push_back(8'h01); exp_q.push_back(8'hC0);
        got = {7'd0, irq}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t1_irq: got %02h expected %02h", got, want); end
        peek(4'hD, got); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t1_ifr: got %02h expected %02h", got, want); end
        exp_q.push_back(8'hFF);
        bus_read(4'h4, got); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t1_cnt_lo: got %02h expected %02h", got, want); end
        exp_q.push_back(8'h00);
        got = {7'd0, irq}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t1_read_clear: got %02h expected %02h", got, want); end
        repeat (6) strobe();
        exp_q.push_back(8'h00);
        got = {7'd0, irq}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t1_no_rearm: got %02h expected %02h", got, want); end
    endtask

    task automatic test_t1_freerun();
        logic pb7_exp;
        bus_write(4'hB, 8'hC0);
        bus_write(4'h4, 8'h02);
        bus_write(4'h5, 8'h00);
        pb7_exp = 1'b0;
        exp_q.push_back(8'h8F); exp_q.push_back(8'h25);
        got = port_b_t; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL fr_pb_t: got %02h expected %02h", got, want); end
        got = port_b_o; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL fr_pb_o_load: got %02h expected %02h", got, want); end
        for (int k = 0; k < 3; k++) begin
            repeat (2) strobe();
            exp_q.push_back(8'h00);
            peek(4'hD, got); got = got & 8'h40; want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL fr_quiet%0d: got %02h expected %02h", k, got, want); end
            strobe();
            pb7_exp = ~pb7_exp;
            exp_q.push_back(8'h40); exp_q.push_back({pb7_exp, 7'd0});
            peek(4'hD, got); got = got & 8'h40; want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL fr_flag%0d: got %02h expected %02h", k, got, want); end
            got = port_b_o & 8'h80; want = exp_q.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL fr_pb7_%0d: got %02h expected %02h", k, got, want); end
            bus_write(4'hD, 8'h40);
        end
        bus_write(4'hB, 8'h00);
        bus_write(4'hE, 8'h40);
    endtask

    task automatic test_ca1();
        bus_write(4'hC, 8'h01);
        bus_write(4'hE, 8'h82);
        exp_q.push_back(8'h82);
        peek(4'hE, got); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ier_read: got %02h expected %02h", got, want); end
        ca1_i = 1'b1;
        strobe();
        exp_q.push_back(8'h01);
        got = {7'd0, irq}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ca1_irq: got %02h expected %02h", got, want); end
        exp_q.push_back(8'h5A); exp_q.push_back(8'h01);
        bus_read(4'hF, got); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ca1_regf_data: got %02h expected %02h", got, want); end
        got = {7'd0, irq}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ca1_regf_keeps: got %02h expected %02h", got, want); end
        bus_read(4'h1, got);
        exp_q.push_back(8'h00);
        got = {7'd0, irq}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ca1_reg1_clears: got %02h expected %02h", got, want); end
        ca1_i = 1'b0;
        strobe();
        exp_q.push_back(8'h00);
        got = {7'd0, irq}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ca1_wrong_edge: got %02h expected %02h", got, want); end
    endtask

    task automatic test_ca2_pulse();
        bus_write(4'hC, 8'h0A);
        strobe();
        exp_q.push_back(8'h03);
        got = {6'd0, ca2_t, ca2_o}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ca2_idle: got %02h expected %02h", got, want); end
        bus_write(4'h1, 8'h00);
        exp_q.push_back(8'h02);
        got = {6'd0, ca2_t, ca2_o}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ca2_pulse_low: got %02h expected %02h", got, want); end
        strobe();
        exp_q.push_back(8'h03);
        got = {6'd0, ca2_t, ca2_o}; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL ca2_pulse_end: got %02h expected %02h", got, want); end
    endtask

    task automatic test_t2_count();
        port_b_i = 8'h7C;
        bus_write(4'h8, 8'h02);
        bus_write(4'hB, 8'h20);
        bus_write(4'h9, 8'h00);
        strobe();
        exp_q.push_back(8'h02); exp_q.push_back(8'h00);
        peek(4'h8, got); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t2_hold_lo: got %02h expected %02h", got, want); end
        peek(4'h9, got); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t2_hold_hi: got %02h expected %02h", got, want); end
        for (int e = 0; e < 3; e++) begin
            port_b_i[6] = 1'b0; strobe();
            port_b_i[6] = 1'b1; strobe();
            if (e == 1) begin
                exp_q.push_back(8'h00);
                peek(4'hD, got); got = got & 8'h20; want = exp_q.pop_front(); n_cmp++;
                if (got !== want) begin n_bad++; $display("FAIL t2_not_yet: got %02h expected %02h", got, want); end
            end
        end
        exp_q.push_back(8'h20);
        peek(4'hD, got); got = got & 8'h20; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t2_flag: got %02h expected %02h", got, want); end
        exp_q.push_back(8'hFF);
        bus_read(4'h8, got); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t2_cnt_lo: got %02h expected %02h", got, want); end
        exp_q.push_back(8'h00);
        peek(4'hD, got); got = got & 8'h20; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t2_read_clear: got %02h expected %02h", got, want); end
        port_b_i[6] = 1'b0; strobe();
        port_b_i[6] = 1'b1; strobe();
        exp_q.push_back(8'h00);
        peek(4'hD, got); got = got & 8'h20; want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL t2_disarmed: got %02h expected %02h", got, want); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.rising = 1'b0; bus.falling = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0;
        bus.addr = 4'h0; bus.data_in = 8'h00;
        port_a_i = 8'h00; port_b_i = 8'h00;
        ca1_i = 1'b0; ca2_i = 1'b0; cb1_i = 1'b0; cb2_i = 1'b0;
        test_reset();
        test_ports();
        test_t1_oneshot();
        test_t1_freerun();
        test_ca1();
        test_ca2_pulse();
        test_t2_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/drive_via6522.md
Name: drive_via6522

Overview:
- Cycle-based model of a MOS 6522 VIA used twice in the 1541 drive logic: serial-bus/parallel-port VIA and disk-controller VIA.
- CPU register access, two 8-bit ports with data-direction registers, CA1/CA2/CB1/CB2 control lines, two 16-bit timers, and an interrupt flag/enable pair.
- All state advances only on the phase strobes supplied by the drive clock divider.

Parameters:
- none

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- rising  in  1  one-cycle strobe, start of CPU phase 2 (no state change required on it)
- falling  in  1  one-cycle strobe, end of CPU phase 2; every register/timer/edge update happens here
- addr  in  4  register select
- wen  in  1  write access this bus cycle
- ren  in  1  read access this bus cycle
- data_in  in  8  CPU write data
- data_out  out  8  read data, combinational from addr
- port_a_o / port_b_o  out  8  output registers ORA / ORB
- port_a_t / port_b_t  out  8  drive enables (=DDRA / DDRB, 1 = output)
- port_a_i / port_b_i  in  8  pin levels
- ca1_i  in  1  CA1 input
- ca2_o, ca2_t  out  1  CA2 level and drive enable
- ca2_i  in  1  CA2 input
- cb1_o, cb1_t  out  1  CB1 level and drive enable; always 1 and 0
- cb1_i  in  1  CB1 input
- cb2_o, cb2_t  out  1  CB2 level and drive enable
- cb2_i  in  1  CB2 input
- irq  out  1  active-high interrupt

Behaviour:
- Reset: ORA, ORB, DDRA, DDRB, ACR, PCR, IFR, IER, SR, timer counters and latches = 0; T1/T2 disarmed; all *_o = 0 except cb1_o = 1; all *_t = 0; irq = 0.
- Writes commit at falling && wen. Read side effects (flag clears) apply at falling && ren.
- Register map:
  - 0 ORB/IRB; 1 ORA/IRA (with handshake); 2 DDRB; 3 DDRA
  - 4 T1C-L; 5 T1C-H; 6 T1L-L; 7 T1L-H
  - 8 T2C-L; 9 T2C-H; A SR; B ACR; C PCR
  - D IFR; E IER; F ORA/IRA (no handshake)
- Port reads:
  - PB read = (ORB & DDRB) | (pin & ~DDRB).
  - PA read = pin value.
  - If ACR0 (PA) or ACR1 (PB) is set, the read returns the value latched at the last active CA1 (PA) or CB1 (PB) edge.
- IFR bits: 0 CA2, 1 CA1, 2 SR, 3 CB2, 4 CB1, 5 T2, 6 T1, 7 = irq.
  - Writing 1s to IFR clears those bits.
  - irq = |(IFR[6:0] & IER[6:0]).
- IER:
  - Write with data_in[7]=1 sets the bits given by data_in[6:0]; with data_in[7]=0 clears them.
  - Reads return bit7 = 1.
- CA1: active edge per PCR0 (0 = falling, 1 = rising), detected by comparing ca1_i at successive falling strobes; sets IFR1. Read/write of reg 1 clears IFR1 and IFR0; reg F clears nothing. CB1 likewise with PCR4, IFR4, reg 0.
- CA2 mode, PCR[3:1]:
  - 000 input, falling edge.
  - 001 input, falling edge, independent (no clear on port access).
  - 010 input, rising edge.
  - 011 input, rising edge, independent.
  - Input modes: active edge sets IFR0.
  - 100 handshake: ca2_o goes low after a reg-1 read/write; returns high on active CA1 edge.
  - 101 pulse: ca2_o low for exactly one falling-to-falling period after a reg-1 access.
  - 110 constant low; 111 constant high.
  - ca2_t = PCR3.
- CB2 mode, PCR[7:5]: same modes using IFR3, cb2_i, CB1 and reg 0; handshake/pulse triggered by reg-0 write only.
- Timer T1:
  - Reg 4/6 write: latch low.
  - Reg 7 write: latch high, clear IFR6.
  - Reg 5 write: latch high, counter = latch, clear IFR6, arm, PB7 output low.
  - Reg 4 read returns counter low and clears IFR6; reg 5 returns counter high; regs 6/7 return latches.
  - Counter decrements every falling strobe except the strobe of loading.
  - Underflow at 0 → FFFF: set IFR6 if armed.
  - One-shot (ACR6=0): disarm after underflow; counter keeps free-decrementing.
  - Free-run (ACR6=1): at the strobe after underflow, load latch instead of decrementing; period is N+2 strobes.
  - ACR7=1: port_b_t[7] forced 1; port_b_o[7] toggles at each armed underflow.
- Timer T2:
  - Reg 8 write: latch low.
  - Reg 9 write: counter = {data_in, latch low}, clear IFR5, arm.
  - Reg 8 read clears IFR5.
  - ACR5=0: decrement each falling strobe. ACR5=1: decrement on each falling edge of port_b_i[6].
  - Underflow when armed: set IFR5, disarm; no reload.
- SR: no shifting. Reg A is plain read/write storage; any access clears IFR2; IFR2 is never set.
- Simultaneous set and clear of a flag in one strobe: set wins.

Test Plan:
- Reset, then read all 16 addresses → 0, except reg D = 0x00 and reg E = 0x80; port_*_t = 0; irq = 0.
- Write DDRB = 0x0F, ORB = 0xA5, port_b_i = 0x3C → reg 0 reads 0x35; port_b_o = 0xA5; port_b_t = 0x0F.
- T1 one-shot:
  - Write reg 4 = 0x03, reg 5 = 0x00, IER = 0xC0.
  - IFR6 and irq assert at the 4th falling strobe after the load strobe; no second interrupt.
  - Reg 4 read clears irq.
- T1 free-run (ACR = 0xC0, latch = 2): IFR6 reasserts every 4 strobes after each clear; port_b_o[7] toggles each time.
- CA1: PCR = 0x01, IER = 0x82, ca1_i 0→1 → irq = 1; reg F read keeps it at 1; reg 1 read → irq = 0.
- CA2 pulse (PCR = 0x0A): write reg 1 → ca2_o = 0 for one strobe period then 1; ca2_t = 1. T2 pulse count (ACR = 0x20, T2 = 2): 3 falling edges on port_b_i[6] → IFR5 = 1.
